// File: rtl/cpu_defines.sv
// Shared definitions for the fetch front end: FSM encoding, NOP word and default reset PC.
package cpu_defines;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: one-word request/acknowledge, read-only.
// req is held with a stable addr until ack; ack may come in the first req cycle and
// completes the transfer that cycle with rdata valid; ack while req=0 is meaningless.
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: {pc, inst, valid, delay-slot} with load, bubble, hold and flush.
module if_id_reg
    import cpu_defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    input  logic        i_ds,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_valid,
    output logic        o_ds
);

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_valid;
    logic        r_ds;

    // A bubble keeps the old pc so decode still sees a sensible address on an empty slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= 32'h0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
            r_ds    <= 1'b0;
        end else if (i_flush || (!i_load && i_bubble)) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
            r_ds    <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_inst  <= i_inst;
            r_valid <= 1'b1;
            r_ds    <= i_ds;
        end
    end

    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;
    assign o_ds    = r_ds;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, imem handshake with a one-word skid buffer,
// delay-slot aware branch redirect, backend stall and exception flush.
module if_stage
    import cpu_defines::*;
#(
    parameter logic [31:0] RESET_PC = cpu_defines::DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [31:0]        flush_pc_i,
    input  logic               branch_flag_i,
    input  logic [31:0]        branch_target_i,
    if_stage_if.master         imem,
    output logic [31:0]        id_pc_o,
    output logic [31:0]        id_inst_o,
    output logic               id_valid_o,
    output logic               id_is_in_delayslot_o,
    output fetch_state_e       dbg_state_o,
    output logic               dbg_pend_valid_o
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_pend_target;
    logic         r_pend_valid;
    logic [31:0]  r_buf_inst;

    logic         w_req;
    logic         w_ack;
    logic         w_handoff;
    logic         w_capture;
    logic         w_bubble;
    logic         w_take;
    logic         w_ds;
    logic [31:0]  w_next_pc;
    logic [31:0]  w_hand_inst;
    logic         w_id_valid;

    assign w_req     = (r_state == S_FETCH) && !rst;
    assign imem.req  = w_req;
    assign imem.addr = r_pc;

    assign w_ack     = w_req && imem.ack;
    assign w_handoff = (r_state == S_FETCH) ? (w_ack && !stall_i) : !stall_i;
    assign w_capture = w_ack && stall_i;
    assign w_bubble  = (r_state == S_FETCH) && !w_ack && !stall_i;

    // The branch leaves decode exactly when decode is not stalled; the word handed off
    // alongside it (or the first one after, if pending) is its delay slot.
    assign w_take      = branch_flag_i && w_id_valid && !stall_i;
    assign w_ds        = w_take || r_pend_valid;
    assign w_next_pc   = !w_ds ? (r_pc + 32'd4)
                       : (w_take ? branch_target_i : r_pend_target);
    assign w_hand_inst = (r_state == S_HOLD) ? r_buf_inst : imem.rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'h0;
            r_buf_inst    <= NOP_INST;
        end else if (flush_i) begin
            r_state      <= S_FETCH;
            r_pc         <= flush_pc_i;
            r_pend_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_capture) begin
                        r_state    <= S_HOLD;
                        r_buf_inst <= imem.rdata;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase

            if (w_handoff) begin
                r_pc         <= w_next_pc;
                r_pend_valid <= 1'b0;
            end else if (w_take) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= branch_target_i;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush_i),
        .i_load   (w_handoff),
        .i_bubble (w_bubble),
        .i_pc     (r_pc),
        .i_inst   (w_hand_inst),
        .i_ds     (w_ds),
        .o_pc     (id_pc_o),
        .o_inst   (id_inst_o),
        .o_valid  (w_id_valid),
        .o_ds     (id_is_in_delayslot_o)
    );

    assign id_valid_o       = w_id_valid;
    assign dbg_state_o      = r_state;
    assign dbg_pend_valid_o = r_pend_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: cycle-exact literal checks plus an in-order
// instruction-stream scoreboard checked on every cycle.
module tb_if_stage;
  import cpu_defines::*;

  localparam logic [31:0] BR_PC  = 32'h0000_0020;
  localparam logic [31:0] BR_TGT = 32'h0000_0100;
  localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

  logic               clk;
  logic               rst;
  logic               stall_i;
  logic               flush_i;
  logic [31:0]        flush_pc_i;
  logic               branch_flag_i;
  logic [31:0]        branch_target_i;
  logic [31:0]        id_pc_o;
  logic [31:0]        id_inst_o;
  logic               id_valid_o;
  logic               id_is_in_delayslot_o;
  fetch_state_e       dbg_state_o;
  logic               dbg_pend_valid_o;
  logic               ack_en;

  int n_vec;
  int n_err;

  logic [32:0] exp_q[$];
  logic        p_rst;
  logic        p_stall;
  logic        p_flush;

  if_stage_if imem_bus ();

  if_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall_i              (stall_i),
    .flush_i              (flush_i),
    .flush_pc_i           (flush_pc_i),
    .branch_flag_i        (branch_flag_i),
    .branch_target_i      (branch_target_i),
    .imem                 (imem_bus),
    .id_pc_o              (id_pc_o),
    .id_inst_o            (id_inst_o),
    .id_valid_o           (id_valid_o),
    .id_is_in_delayslot_o (id_is_in_delayslot_o),
    .dbg_state_o          (dbg_state_o),
    .dbg_pend_valid_o     (dbg_pend_valid_o)
  );

  // memory echoes the address as the instruction word; decode branches at BR_PC only
  assign imem_bus.rdata  = imem_bus.addr;
  assign imem_bus.ack    = ack_en;
  assign branch_flag_i   = id_valid_o && !id_is_in_delayslot_o && (id_pc_o == BR_PC);
  assign branch_target_i = BR_TGT;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs, return half a cycle after the edge
  task automatic step(input logic s, input logic f, input logic [31:0] fp, input logic a);
    stall_i    = s;
    flush_i    = f;
    flush_pc_i = fp;
    ack_en     = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_id(input string name, input logic [31:0] pc, input logic v, input logic ds);
    chk({name, "_valid"}, {31'b0, id_valid_o}, {31'b0, v});
    if (v) begin
      chk({name, "_pc"}, id_pc_o, pc);
      chk({name, "_ds"}, {31'b0, id_is_in_delayslot_o}, {31'b0, ds});
    end else begin
      chk({name, "_inst"}, id_inst_o, NOP_INST);
    end
  endtask

  task automatic chk_req(input string name, input logic r, input logic [31:0] a);
    chk({name, "_req"}, {31'b0, imem_bus.req}, {31'b0, r});
    if (r) chk({name, "_addr"}, imem_bus.addr, a);
  endtask

  // scoreboard: expected program order of delivered instructions
  always @(posedge clk) begin
    p_rst   = rst;
    p_stall = stall_i;
    p_flush = flush_i;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back({1'b0, DEFAULT_RESET_PC});
    end else if (flush_i) begin
      exp_q.delete();
      exp_q.push_back({1'b0, flush_pc_i});
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (!p_rst) begin
      if (!id_valid_o) begin
        chk("bubble_inst", id_inst_o, NOP_INST);
        chk("bubble_ds", {31'b0, id_is_in_delayslot_o}, 32'h0);
      end else begin
        chk("inst_word", id_inst_o, id_pc_o);
        if (!p_stall && !p_flush) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL stream_empty: got pc %h expected no delivery", id_pc_o);
          end else begin
            e = exp_q.pop_front();
            chk("stream_pc", id_pc_o, e[31:0]);
            chk("stream_ds", {31'b0, id_is_in_delayslot_o}, {31'b0, e[32]});
            if (e[32])              exp_q.push_back({1'b0, BR_TGT});
            else if (e[31:0] == BR_PC) exp_q.push_back({1'b1, e[31:0] + 32'd4});
            else                    exp_q.push_back({1'b0, e[31:0] + 32'd4});
          end
        end
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    p_rst = 1'b1;
    p_stall = 1'b0;
    p_flush = 1'b0;
    rst = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    flush_pc_i = 32'h0;
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    chk_req("reset", 1'b0, 32'h0);
    chk("reset_id_pc", id_pc_o, 32'h0);
    chk_id("reset", 32'h0, 1'b0, 1'b0);
    chk("reset_pend", {31'b0, dbg_pend_valid_o}, 32'h0);
    rst = 1'b0;
    #1;
    chk_req("c0", 1'b1, 32'h0);

    // sequential fetch, then ack delayed two cycles on pc=8
    step(0, 0, 0, 1); chk_id("c1", 32'h0, 1, 0); chk_req("c1", 1, 32'h4);
    step(0, 0, 0, 1); chk_id("c2", 32'h4, 1, 0); chk_req("c2", 1, 32'h8);
    step(0, 0, 0, 0); chk_id("c3", 32'h0, 0, 0); chk_req("c3", 1, 32'h8);
    step(0, 0, 0, 0); chk_id("c4", 32'h0, 0, 0); chk_req("c4", 1, 32'h8);
    step(0, 0, 0, 1); chk_id("c5", 32'h8, 1, 0); chk_req("c5", 1, 32'hC);
    step(0, 0, 0, 1); chk_id("c6", 32'hC, 1, 0); chk_req("c6", 1, 32'h10);

    // stall three cycles while pc=16 is acked
    step(1, 0, 0, 1); chk_id("c7", 32'hC, 1, 0); chk_req("c7", 0, 32'h0);
    chk("c7_state", {31'b0, dbg_state_o}, {31'b0, S_HOLD});
    step(1, 0, 0, 0); chk_id("c8", 32'hC, 1, 0); chk_req("c8", 0, 32'h0);
    step(1, 0, 0, 1); chk_id("c9", 32'hC, 1, 0); chk_req("c9", 0, 32'h0);
    step(0, 0, 0, 0); chk_id("c10", 32'h10, 1, 0); chk_req("c10", 1, 32'h14);

    // branch at 0x20 with ack every cycle
    repeat (4) step(0, 0, 0, 1);
    chk_id("c14", BR_PC, 1, 0); chk_req("c14", 1, 32'h24);
    step(0, 0, 0, 1); chk_id("c15", 32'h24, 1, 1); chk_req("c15", 1, BR_TGT);
    step(0, 0, 0, 1); chk_id("c16", BR_TGT, 1, 0); chk_req("c16", 1, 32'h104);

    // same branch again with the delay-slot ack delayed three cycles
    step(0, 1, BR_PC, 1); chk_id("c17", 32'h0, 0, 0); chk_req("c17", 1, BR_PC);
    step(0, 0, 0, 1); chk_id("c18", BR_PC, 1, 0); chk_req("c18", 1, 32'h24);
    step(0, 0, 0, 0); chk_id("c19", 32'h0, 0, 0); chk_req("c19", 1, 32'h24);
    chk("c19_pend", {31'b0, dbg_pend_valid_o}, 32'h1);
    step(0, 0, 0, 0); chk_id("c20", 32'h0, 0, 0);
    step(0, 0, 0, 0); chk_id("c21", 32'h0, 0, 0); chk_req("c21", 1, 32'h24);
    step(0, 0, 0, 1); chk_id("c22", 32'h24, 1, 1); chk_req("c22", 1, BR_TGT);
    step(0, 0, 0, 1); chk_id("c23", BR_TGT, 1, 0);

    // flush during a stalled HOLD with a pending redirect
    step(0, 1, BR_PC, 1); chk_id("c24", 32'h0, 0, 0); chk_req("c24", 1, BR_PC);
    step(0, 0, 0, 1); chk_id("c25", BR_PC, 1, 0);
    step(0, 0, 0, 0); chk_id("c26", 32'h0, 0, 0);
    chk("c26_pend", {31'b0, dbg_pend_valid_o}, 32'h1);
    step(1, 0, 0, 1); chk_id("c27", 32'h0, 0, 0); chk_req("c27", 0, 32'h0);
    step(1, 1, EXC_PC, 0); chk_id("c28", 32'h0, 0, 0); chk_req("c28", 1, EXC_PC);
    chk("c28_pend", {31'b0, dbg_pend_valid_o}, 32'h0);
    step(0, 0, 0, 1); chk_id("c29", EXC_PC, 1, 0); chk_req("c29", 1, EXC_PC + 32'd4);
    step(0, 0, 0, 1); chk_id("c30", EXC_PC + 32'd4, 1, 0);

    // reset mid-fetch: request drops in the same cycle, late ack ignored
    rst = 1'b1;
    #1;
    chk_req("rst_mid", 0, 32'h0);
    step(0, 0, 0, 1); chk_id("rst_hold", 32'h0, 0, 0); chk("rst_pc", id_pc_o, 32'h0);
    rst = 1'b0;
    #1;
    chk_req("rst_rel", 1, DEFAULT_RESET_PC);
    step(0, 0, 0, 1); chk_id("rst_first", 32'h0, 1, 0);

    // mixed stall/ack/flush traffic, checked by the stream scoreboard
    for (int i = 0; i < 400; i++) begin
      logic f;
      f = ($urandom_range(0, 40) == 0);
      step($urandom_range(0, 3) == 0, f,
           ($urandom_range(0, 1) == 0) ? BR_PC : EXC_PC,
           $urandom_range(0, 2) != 0);
    end
    step(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
